// File: rtl/sync_manager.sv
// Active-geometry measurement for an RGB-domain DVI/HDMI stream: validated width/height plus
// per-line and per-frame strobes, all in the recovered pixel-clock domain.
module sync_manager #(
  parameter int unsigned MAX_WIDTH      = 1920,
  parameter int unsigned MAX_HEIGHT     = 1080,
  parameter int unsigned DELAY          = 0,
  parameter bit          VS_ACTIVE_HIGH = 1'b1
) (
  input  logic                          I_rgb_clk,
  input  logic                          I_rst,
  input  logic                          I_rgb_de,
  input  logic                          I_rgb_hs,
  input  logic                          I_rgb_vs,
  output logic [$clog2(MAX_WIDTH)-1:0]  O_image_width,
  output logic [$clog2(MAX_HEIGHT)-1:0] O_image_height,
  output logic                          O_width_valid,
  output logic                          O_height_valid,
  output logic                          O_new_row,
  output logic                          O_new_frame,
  output logic                          O_image_valid
);

  localparam int unsigned WW = $clog2(MAX_WIDTH);
  localparam int unsigned HW = $clog2(MAX_HEIGHT);
  // Saturation limits, clipped to what the port width can hold when MAX_* is a power of two.
  localparam int unsigned WLIM = (MAX_WIDTH < (1 << WW)) ? MAX_WIDTH : (1 << WW) - 1;
  localparam int unsigned HLIM = (MAX_HEIGHT < (1 << HW)) ? MAX_HEIGHT : (1 << HW) - 1;

  logic          de_q, de_q2, hs_q, vs_q, vs_q2;
  logic          de_rise, de_fall, vs_edge;
  logic          armed;
  logic [WW-1:0] pix_cnt, prev_width;
  logic [HW-1:0] line_cnt, prev_height, lines_now;
  logic [DELAY:0] row_pipe, frame_pipe;
  logic          unused_hs;

  assign de_rise = de_q & ~de_q2;
  assign de_fall = ~de_q & de_q2;
  assign vs_edge = VS_ACTIVE_HIGH ? (vs_q & ~vs_q2) : (~vs_q & vs_q2);

  // HS is carried for timing alignment only; nothing in the measurement depends on it.
  assign unused_hs = hs_q;

  // A line ending in the same cycle as the frame edge belongs to the frame that is closing.
  always_comb begin
    lines_now = line_cnt;
    if (de_fall && (line_cnt != HW'(HLIM))) begin
      lines_now = line_cnt + HW'(1);
    end
  end

  always_ff @(posedge I_rgb_clk) begin
    if (I_rst) begin
      de_q           <= 1'b0;
      de_q2          <= 1'b0;
      hs_q           <= 1'b0;
      vs_q           <= 1'b0;
      vs_q2          <= 1'b0;
      armed          <= 1'b0;
      pix_cnt        <= '0;
      prev_width     <= '0;
      line_cnt       <= '0;
      prev_height    <= '0;
      row_pipe       <= '0;
      frame_pipe     <= '0;
      O_image_width  <= '0;
      O_image_height <= '0;
      O_width_valid  <= 1'b0;
      O_height_valid <= 1'b0;
      O_image_valid  <= 1'b0;
    end else begin
      de_q  <= I_rgb_de;
      de_q2 <= de_q;
      hs_q  <= I_rgb_hs;
      vs_q  <= I_rgb_vs;
      vs_q2 <= vs_q;

      if (de_rise) begin
        pix_cnt <= WW'(1);
      end else if (de_q && (pix_cnt != WW'(WLIM))) begin
        pix_cnt <= pix_cnt + WW'(1);
      end

      if (de_fall) begin
        if ((pix_cnt == prev_width) && (pix_cnt != '0)) begin
          O_width_valid <= 1'b1;
          O_image_width <= pix_cnt;
        end else begin
          O_width_valid <= 1'b0;
          prev_width    <= pix_cnt;
        end
      end

      if (vs_edge) begin
        line_cnt <= '0;
        armed    <= 1'b1;
        if (armed) begin
          if ((lines_now == prev_height) && (lines_now != '0)) begin
            O_height_valid <= 1'b1;
            O_image_height <= lines_now;
          end else begin
            O_height_valid <= 1'b0;
            prev_height    <= lines_now;
          end
        end
      end else begin
        line_cnt <= lines_now;
      end

      row_pipe      <= (DELAY + 1)'({row_pipe, de_fall});
      frame_pipe    <= (DELAY + 1)'({frame_pipe, vs_edge});
      O_image_valid <= O_width_valid & O_height_valid;
    end
  end

  assign O_new_row   = row_pipe[DELAY];
  assign O_new_frame = frame_pipe[DELAY];

endmodule

// File: tb/tb_sync_manager.sv
// Scoreboard bench for sync_manager: the driver predicts every strobe and the geometry visible
// with it; negedge monitors pop and compare for a DELAY=0 and a DELAY=3 instance.
module tb_sync_manager;

  localparam int WW = $clog2(1920);
  localparam int HW = $clog2(1080);

  logic clk = 1'b0;
  logic rst, de, hs, vs;

  logic [WW-1:0] w0, w3;
  logic [HW-1:0] h0, h3;
  logic wv0, hv0, row0, frame0, iv0;
  logic wv3, hv3, row3, frame3, iv3;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sync_manager #(.DELAY(0)) dut (
    .I_rgb_clk(clk), .I_rst(rst), .I_rgb_de(de), .I_rgb_hs(hs), .I_rgb_vs(vs),
    .O_image_width(w0), .O_image_height(h0), .O_width_valid(wv0), .O_height_valid(hv0),
    .O_new_row(row0), .O_new_frame(frame0), .O_image_valid(iv0)
  );

  sync_manager #(.DELAY(3)) dut3 (
    .I_rgb_clk(clk), .I_rst(rst), .I_rgb_de(de), .I_rgb_hs(hs), .I_rgb_vs(vs),
    .O_image_width(w3), .O_image_height(h3), .O_width_valid(wv3), .O_height_valid(hv3),
    .O_new_row(row3), .O_new_frame(frame3), .O_image_valid(iv3)
  );

  typedef struct {
    int cyc;
    bit row;
    bit frame;
    bit wv;
    int w;
    bit hv;
    int h;
    bit iv;
  } exp_t;

  exp_t q0[$];
  exp_t q3[$];

  int vectors = 0;
  int miscompares = 0;

  // Reference model state, updated as pins are driven.
  bit de_prev, vs_prev, wv_m, hv_m, armed_m;
  int pix_m, pw_m, ph_m, w_m, h_m, lines_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_zero(input string name);
    check(name, {3'b0, w0, h0, wv0, hv0, row0, frame0, iv0, row3, frame3}, 32'd0);
  endtask

  task automatic model_reset();
    de_prev = 1'b0; vs_prev = 1'b0; wv_m = 1'b0; hv_m = 1'b0; armed_m = 1'b0;
    pix_m = 0; pw_m = 0; ph_m = 0; w_m = 0; h_m = 0; lines_m = 0;
  endtask

  task automatic drive(input bit d, input bit v);
    exp_t e;
    bit fall, vsr, old_iv;
    fall   = de_prev && !d;
    vsr    = !vs_prev && v;
    old_iv = wv_m && hv_m;
    if (d && !de_prev) pix_m = 0;
    if (d) pix_m++;
    if (fall) begin
      lines_m++;
      if (pix_m == pw_m && pix_m != 0) begin wv_m = 1'b1; w_m = pix_m; end
      else begin wv_m = 1'b0; pw_m = pix_m; end
    end
    if (vsr) begin
      if (armed_m) begin
        if (lines_m == ph_m && lines_m != 0) begin hv_m = 1'b1; h_m = lines_m; end
        else begin hv_m = 1'b0; ph_m = lines_m; end
      end
      armed_m = 1'b1;
      lines_m = 0;
    end
    if (fall || vsr) begin
      e.cyc = cyc + 2; e.row = fall; e.frame = vsr;
      e.wv = wv_m; e.w = w_m; e.hv = hv_m; e.h = h_m; e.iv = old_iv;
      q0.push_back(e);
      e.cyc = cyc + 5;
      q3.push_back(e);
    end
    de = d; vs = v; hs = 1'($urandom_range(1));
    de_prev = d; vs_prev = v;
    @(posedge clk);
    #1;
  endtask

  // 16x16 raster: active area ha x va in the top-left, VS high for 16 cycles from (vl, vc).
  task automatic drive_frame(input int ha, input int va, input int vl, input int vc,
                             input int first, input int last);
    int l, c;
    bit d, v;
    for (int n = first; n < last; n++) begin
      l = n / 16;
      c = n % 16;
      d = (l < va) && (c < ha);
      v = (l == vl && c >= vc) || (l == vl + 1 && c < vc);
      drive(d, v);
    end
  endtask

  task automatic pop0();
    exp_t e;
    vectors++;
    if (q0.size() == 0) begin
      miscompares++;
      $display("FAIL strobe_d0: unexpected row=%b frame=%b at cycle %0d", row0, frame0, cyc);
    end else begin
      e = q0.pop_front();
      if (cyc != e.cyc || row0 !== e.row || frame0 !== e.frame || wv0 !== e.wv ||
          w0 !== WW'(e.w) || hv0 !== e.hv || h0 !== HW'(e.h) || iv0 !== e.iv) begin
        miscompares++;
        $display("FAIL strobe_d0: got cyc=%0d row=%b frame=%b wv=%b w=%0d hv=%b h=%0d iv=%b, required cyc=%0d row=%b frame=%b wv=%b w=%0d hv=%b h=%0d iv=%b",
                 cyc, row0, frame0, wv0, w0, hv0, h0, iv0,
                 e.cyc, e.row, e.frame, e.wv, e.w, e.hv, e.h, e.iv);
      end
    end
  endtask

  task automatic pop3();
    exp_t e;
    vectors++;
    if (q3.size() == 0) begin
      miscompares++;
      $display("FAIL strobe_d3: unexpected row=%b frame=%b at cycle %0d", row3, frame3, cyc);
    end else begin
      e = q3.pop_front();
      if (cyc != e.cyc || row3 !== e.row || frame3 !== e.frame) begin
        miscompares++;
        $display("FAIL strobe_d3: got cyc=%0d row=%b frame=%b, required cyc=%0d row=%b frame=%b",
                 cyc, row3, frame3, e.cyc, e.row, e.frame);
      end
    end
  endtask

  always @(negedge clk) begin
    if (row0 === 1'b1 || frame0 === 1'b1) pop0();
    if (row3 === 1'b1 || frame3 === 1'b1) pop3();
  end

  initial begin
    rst = 1'b1; de = 1'b0; hs = 1'b0; vs = 1'b0;
    model_reset();

    // Power-up reset with random syncs on the pins.
    for (int i = 0; i < 5; i++) begin
      de = 1'($urandom_range(1)); hs = 1'($urandom_range(1)); vs = 1'($urandom_range(1));
      @(posedge clk);
      #1;
      check_zero("reset_hold");
    end
    de = 1'b0; vs = 1'b0;
    @(posedge clk);
    #1;
    check_zero("reset_quiet");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0);
      check_zero("post_reset_idle");
    end

    // Width lock, then height lock over three VS edges.
    drive_frame(4, 4, 10, 0, 0, 8);
    check("width_valid_line1", wv0, 0);
    drive_frame(4, 4, 10, 0, 8, 24);
    check("width_valid_line2", {wv0, 3'b0, w0}, {1'b1, 3'b0, 11'd4});
    drive_frame(4, 4, 10, 0, 24, 256);
    drive_frame(4, 4, 10, 0, 0, 256);
    check("height_valid_edge2", hv0, 0);
    drive_frame(4, 4, 10, 0, 0, 256);
    check("height_lock", {hv0, 3'b0, h0, iv0}, {1'b1, 3'b0, 11'd4, 1'b1});

    // Width change 4 -> 6.
    drive_frame(6, 4, 10, 0, 0, 8);
    check("width_change_line1", {wv0, 3'b0, w0}, {1'b0, 3'b0, 11'd4});
    drive_frame(6, 4, 10, 0, 8, 24);
    check("width_change_line2", {wv0, 3'b0, w0}, {1'b1, 3'b0, 11'd6});
    drive_frame(6, 4, 10, 0, 24, 256);

    // VS edge in the same cycle as the last DE fall, then a height change 4 -> 5.
    drive_frame(6, 4, 3, 6, 0, 256);
    drive_frame(6, 4, 3, 6, 0, 256);
    check("coincident_edge", {hv0, 3'b0, h0}, {1'b1, 3'b0, 11'd4});
    drive_frame(6, 5, 10, 0, 0, 256);
    check("height_change_f1", {hv0, 3'b0, h0}, {1'b0, 3'b0, 11'd4});
    drive_frame(6, 5, 10, 0, 0, 256);
    check("height_change_f2", {hv0, 3'b0, h0}, {1'b1, 3'b0, 11'd5});

    // Frames with no DE never validate height.
    for (int i = 0; i < 3; i++) drive_frame(0, 0, 10, 0, 0, 256);
    check("zero_frames", {hv0, 3'b0, h0, iv0}, {1'b0, 3'b0, 11'd5, 1'b0});

    // Mid-frame reset after lock, then re-lock from scratch.
    drive_frame(6, 5, 10, 0, 0, 18);
    check("queues_before_reset", q0.size() + q3.size(), 0);
    rst = 1'b1; de = 1'b0; vs = 1'b0;
    @(posedge clk);
    #1;
    check_zero("mid_frame_reset");
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) drive_frame(4, 4, 10, 0, 0, 256);
    check("relock", {wv0, hv0, iv0, 3'b0, w0, 3'b0, h0}, {3'b111, 3'b0, 11'd4, 3'b0, 11'd4});

    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0);
    check("pending_d0", q0.size(), 0);
    check("pending_d3", q3.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
